// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the sequencer state enum, reset-cause encodings, the warm-count
// width and the helper that sizes the shared cycle counter.
package reset_seq_pkg;

  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned WARM_W  = 8;

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_LOCK,
    HOLD,
    REL_BUS,
    REL_CPU,
    RUN
  } seq_state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_POR  = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_LOCK = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_SW   = 2'd2;

  // Counter width: big enough to reach the largest terminal count without wrap.
  function automatic int unsigned cnt_width(input int unsigned lock_filter,
                                            input int unsigned hold_cycles,
                                            input int unsigned stage_gap);
    int unsigned m;
    m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    if (lock_filter > m) m = lock_filter;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer.
// Inputs to the sequencer: locked (async lock), sw_rst_req (warm request).
// Outputs: bus/cpu/periph active-low domain resets, seq_busy, rst_cause,
// warm_count. slave = the sequencer, master = whoever drives lock/requests.
interface reset_sequencer_if;
  import reset_seq_pkg::*;

  logic                 locked;
  logic                 sw_rst_req;
  logic                 bus_reset;
  logic                 cpu_reset;
  logic                 periph_reset;
  logic                 seq_busy;
  logic [CAUSE_W-1:0]   rst_cause;
  logic [WARM_W-1:0]    warm_count;

  modport master (
    output locked, sw_rst_req,
    input  bus_reset, cpu_reset, periph_reset, seq_busy, rst_cause, warm_count
  );

  modport slave (
    input  locked, sw_rst_req,
    output bus_reset, cpu_reset, periph_reset, seq_busy, rst_cause, warm_count
  );
endinterface

// File: rtl/reset_sequencer_sync_ff.sv
// sync_ff: STAGES-deep flop chain with asynchronous active-low clear.
// Ports: clk, rst_n (async clear), d (async input), q (synchronized output).
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of bus, CPU and peripheral reset domains,
// gated on a filtered clock lock, with warm reset on lock loss or SW request.
// Ports: clk, reset (async active-low chip reset), rs (slave modport:
// locked, sw_rst_req in; domain resets, seq_busy, rst_cause, warm_count out).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic               clk,
  input  logic               reset,
  reset_sequencer_if.slave   rs
);

  localparam int unsigned CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);

  logic rst_sync;
  logic lock_sync;

  // Reset release is synchronized; assertion stays asynchronous.
  sync_ff #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (1'b1),
    .q     (rst_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rs.locked),
    .q     (lock_sync)
  );

  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;      // lock filter / hold / stage gap, one state at a time
  logic                bus_q, bus_d;
  logic                cpu_q, cpu_d;
  logic                periph_q, periph_d;
  logic                busy_q, busy_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [WARM_W-1:0]   warm_q, warm_d;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      bus_q    <= 1'b0;
      cpu_q    <= 1'b0;
      periph_q <= 1'b0;
      busy_q   <= 1'b1;
      cause_q  <= CAUSE_POR;
      warm_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      cpu_q    <= cpu_d;
      periph_q <= periph_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
      warm_q   <= warm_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic               warm_req;
    logic [CAUSE_W-1:0] warm_cause;

    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    cpu_d      = cpu_q;
    periph_d   = periph_q;
    busy_d     = busy_q;
    cause_d    = cause_q;
    warm_d     = warm_q;
    warm_req   = 1'b0;
    warm_cause = CAUSE_LOCK;

    if (rst_sync) begin
      unique case (state_q)
        ASSERT: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
        WAIT_LOCK: begin
          if (!lock_sync) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_sync) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = REL_BUS;
            cnt_d   = '0;
            bus_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL_BUS: begin
          if (!lock_sync) begin
            warm_req = 1'b1;
          end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
            state_d = REL_CPU;
            cnt_d   = '0;
            cpu_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL_CPU: begin
          if (!lock_sync) begin
            warm_req = 1'b1;
          end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
            state_d  = RUN;
            cnt_d    = '0;
            periph_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          // Lock loss wins over a simultaneous software request.
          if (!lock_sync) begin
            warm_req = 1'b1;
          end else if (rs.sw_rst_req) begin
            warm_req   = 1'b1;
            warm_cause = CAUSE_SW;
          end
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      endcase
    end

    // Warm reset: all domains assert together on the same edge.
    if (warm_req) begin
      state_d  = ASSERT;
      cnt_d    = '0;
      bus_d    = 1'b0;
      cpu_d    = 1'b0;
      periph_d = 1'b0;
      busy_d   = 1'b1;
      cause_d  = warm_cause;
      warm_d   = (warm_q == '1) ? warm_q : warm_q + 1'b1;
    end
  end

  assign rs.bus_reset    = bus_q;
  assign rs.cpu_reset    = cpu_q;
  assign rs.periph_reset = periph_q;
  assign rs.seq_busy     = busy_q;
  assign rs.rst_cause    = cause_q;
  assign rs.warm_count   = warm_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer at default parameters.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int SEL_BUS    = 0;
  localparam int SEL_CPU    = 1;
  localparam int SEL_PERIPH = 2;
  localparam int SEL_BUSY   = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   n;
  int   exp_warm;

  reset_sequencer_if rs_if();

  reset_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int cnt);
    repeat (cnt) step();
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      SEL_BUS:    return rs_if.bus_reset;
      SEL_CPU:    return rs_if.cpu_reset;
      SEL_PERIPH: return rs_if.periph_reset;
      default:    return rs_if.seq_busy;
    endcase
  endfunction

  // Returns the number of edges until the selected output equals val, or -1.
  task automatic wait_for(input int sel, input logic val, input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget && cnt < 0; i++) begin
      step();
      if (sel_sig(sel) === val) cnt = i;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic c, input logic p,
                           input logic busy, input logic [1:0] cause, input logic [7:0] warm);
    check({tag, "_bus"},    32'(rs_if.bus_reset),    32'(b));
    check({tag, "_cpu"},    32'(rs_if.cpu_reset),    32'(c));
    check({tag, "_periph"}, 32'(rs_if.periph_reset), 32'(p));
    check({tag, "_busy"},   32'(rs_if.seq_busy),     32'(busy));
    check({tag, "_cause"},  32'(rs_if.rst_cause),    32'(cause));
    check({tag, "_warm"},   32'(rs_if.warm_count),   32'(warm));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rs_if.locked     = 1'b1;
    rs_if.sw_rst_req = 1'b0;
    reset            = 1'b0;

    // POR: reset values while held
    steps(3);
    check_all("por", 1'b0, 1'b0, 1'b0, 1'b1, CAUSE_POR, 8'd0);

    // Release; edge 1 is the next posedge. A sw request sampled at edge 16 (HOLD) is ignored.
    reset = 1'b1;
    steps(15);
    rs_if.sw_rst_req = 1'b1;
    step();
    rs_if.sw_rst_req = 1'b0;
    check("hold_sw_ignored_busy", 32'(rs_if.seq_busy), 32'd1);
    wait_for(SEL_BUS, 1'b1, 40, n);
    check("por_bus_edge27", 32'(n), 32'd11);
    wait_for(SEL_CPU, 1'b1, 10, n);
    check("por_cpu_gap", 32'(n), 32'd4);
    check("por_busy_before_periph", 32'(rs_if.seq_busy), 32'd1);
    wait_for(SEL_PERIPH, 1'b1, 10, n);
    check("por_periph_gap", 32'(n), 32'd4);
    check_all("por_run", 1'b1, 1'b1, 1'b1, 1'b0, CAUSE_POR, 8'd0);

    // Software warm reset from RUN
    steps(2);
    rs_if.sw_rst_req = 1'b1;
    step();
    rs_if.sw_rst_req = 1'b0;
    check_all("sw_warm", 1'b0, 1'b0, 1'b0, 1'b1, CAUSE_SW, 8'd1);
    wait_for(SEL_BUS, 1'b1, 40, n);
    check("sw_bus", 32'(n), 32'd25);
    wait_for(SEL_CPU, 1'b1, 10, n);
    check("sw_cpu_gap", 32'(n), 32'd4);
    wait_for(SEL_PERIPH, 1'b1, 10, n);
    check("sw_periph_gap", 32'(n), 32'd4);
    check("sw_rerun_busy", 32'(rs_if.seq_busy), 32'd0);

    // Lock loss in RUN: two sync edges, then the FSM reacts on the third
    steps(2);
    rs_if.locked = 1'b0;
    steps(2);
    check("lock_lat2_bus", 32'(rs_if.bus_reset), 32'd1);
    step();
    check_all("lock_warm", 1'b0, 1'b0, 1'b0, 1'b1, CAUSE_LOCK, 8'd2);
    steps(20);
    check("lock_wait_busy", 32'(rs_if.seq_busy), 32'd1);
    check("lock_wait_bus", 32'(rs_if.bus_reset), 32'd0);
    rs_if.locked = 1'b1;
    wait_for(SEL_BUS, 1'b1, 40, n);
    check("relock_bus", 32'(n), 32'd26);
    wait_for(SEL_BUSY, 1'b0, 20, n);
    check("relock_run", 32'(n), 32'd8);

    // Lock loss and sw request in the same synchronized cycle
    steps(2);
    rs_if.locked = 1'b0;
    steps(2);
    rs_if.sw_rst_req = 1'b1;
    step();
    rs_if.sw_rst_req = 1'b0;
    check_all("both", 1'b0, 1'b0, 1'b0, 1'b1, CAUSE_LOCK, 8'd3);
    rs_if.locked = 1'b1;
    wait_for(SEL_BUSY, 1'b0, 60, n);
    check("both_rerun", 32'(n), 32'd34);

    // 300 software resets: warm_count saturates at 255
    exp_warm = 3;
    for (int i = 0; i < 300; i++) begin
      step();
      rs_if.sw_rst_req = 1'b1;
      step();
      rs_if.sw_rst_req = 1'b0;
      exp_warm = (exp_warm < 255) ? exp_warm + 1 : 255;
      check("sat_warm", 32'(rs_if.warm_count), 32'(exp_warm));
      wait_for(SEL_BUSY, 1'b0, 60, n);
      check("sat_cycle", 32'(n), 32'd33);
    end
    check("sat_cause", 32'(rs_if.rst_cause), 32'(CAUSE_SW));

    // Async reset in the middle of REL_CPU takes effect without a clock edge
    step();
    rs_if.sw_rst_req = 1'b1;
    step();
    rs_if.sw_rst_req = 1'b0;
    wait_for(SEL_CPU, 1'b1, 40, n);
    check("mid_cpu_rise", 32'(n), 32'd29);
    step();
    #2;
    reset = 1'b0;
    #1;
    check_all("async_mid", 1'b0, 1'b0, 1'b0, 1'b1, CAUSE_POR, 8'd0);

    // One-cycle lock glitch after 5 filtered-high cycles delays release by 6
    steps(3);
    reset = 1'b1;
    steps(6);
    rs_if.locked = 1'b0;
    step();
    rs_if.locked = 1'b1;
    wait_for(SEL_BUS, 1'b1, 60, n);
    check("glitch_bus_edge33", 32'(n), 32'd26);
    check("glitch_cause", 32'(rs_if.rst_cause), 32'(CAUSE_POR));
    check("glitch_warm", 32'(rs_if.warm_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
